// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues word reads, buffers responses in a 2-entry FIFO for decode.
// Optional FETCH_EBREAK_HALT_EN stops fetching after an EBREAK word is delivered.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] Ebreak         = 32'h0010_0073;

    logic [31:0] pc_q;
    logic        pending_q;
    logic [31:0] pending_pc_q;
    logic [31:0] word_q [2];
    logic [31:0] wpc_q  [2];
    logic [1:0]  count_q;
    logic        halted_q;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;
    logic [1:0]  wr_base;
    logic        wr_idx;

    always_comb begin
        pop       = inst_valid & inst_ready;
        occupancy = {1'b0, count_q} + {2'b00, pending_q};
        issue     = !rst && !redirect_valid && !halted_q
                    && (occupancy < (3'd2 + {2'b00, pop}));
`ifdef FETCH_EBREAK_HALT_EN
        // Any response landing while halted belongs to the word after the EBREAK.
        push      = pending_q & !halted_q;
`else
        push      = pending_q;
`endif
        wr_base   = count_q - {1'b0, pop};
        wr_idx    = wr_base[0];
    end

    assign mem_addr     = pc_q;
    assign mem_r_enable = issue;
    assign inst         = word_q[0];
    assign inst_pc      = wpc_q[0];
    assign inst_valid   = (count_q != 2'd0);
    assign halted       = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= ResetPcAligned;
            pending_q    <= 1'b0;
            pending_pc_q <= 32'h0;
            word_q[0]    <= 32'h0;
            word_q[1]    <= 32'h0;
            wpc_q[0]     <= 32'h0;
            wpc_q[1]     <= 32'h0;
            count_q      <= 2'd0;
            halted_q     <= 1'b0;
        end else if (redirect_valid) begin
            pc_q      <= {redirect_pc[31:2], 2'b00};
            pending_q <= 1'b0;
            count_q   <= 2'd0;
            halted_q  <= 1'b0;
        end else begin
            pending_q <= issue;
            if (issue) begin
                pc_q         <= pc_q + 32'd4;
                pending_pc_q <= pc_q;
            end
            // Shift on pop; a push to slot 0 in the same cycle overrides the shift.
            if (pop) begin
                word_q[0] <= word_q[1];
                wpc_q[0]  <= wpc_q[1];
            end
            if (push) begin
                word_q[wr_idx] <= mem_rdata;
                wpc_q[wr_idx]  <= pending_pc_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
`ifdef FETCH_EBREAK_HALT_EN
            if (push && (mem_rdata == Ebreak)) begin
                halted_q <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed opening sequence, then random ready/redirect/reset traffic
// checked every cycle against a queue-based model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] Ebreak = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_r_enable   (mem_r_enable),
        .mem_rdata      (mem_rdata),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    // One-cycle-latency registered instruction memory, 256 words.
    logic [31:0] mem [256];
    always_ff @(posedge clk) begin
        if (mem_r_enable) mem_rdata <= mem[mem_addr[9:2]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: fetch PC, one in-flight read, queue of delivered-but-unconsumed words.
    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;
    ent_t        m_fifo[$];
    logic [31:0] m_pc       = 32'h0;
    bit          m_infl     = 1'b0;
    logic [31:0] m_infl_pc  = 32'h0;
    bit          m_halted   = 1'b0;

    task automatic run_cycle(input bit r_rst, input bit r_ready, input bit r_redir,
                             input logic [31:0] r_pc);
        bit   exp_valid;
        bit   pop;
        bit   issue;
        int   occ;
        ent_t e;
        @(posedge clk);
        #1;
        rst            = r_rst;
        inst_ready     = r_ready;
        redirect_valid = r_redir;
        redirect_pc    = r_pc;
        @(negedge clk);

        exp_valid = (m_fifo.size() != 0);
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check_eq("inst", inst, m_fifo[0].w);
            check_eq("inst_pc", inst_pc, m_fifo[0].pc);
        end
        pop   = exp_valid && r_ready;
        occ   = m_fifo.size() + int'(m_infl) - int'(pop);
        issue = !r_rst && !r_redir && !m_halted && (occ < 2);
        check_eq("mem_r_enable", {31'b0, mem_r_enable}, {31'b0, issue});
        check_eq("mem_addr", mem_addr, m_pc);
        check_eq("halted", {31'b0, halted}, {31'b0, m_halted});

        if (r_rst) begin
            m_fifo.delete();
            m_pc     = 32'h0;
            m_infl   = 1'b0;
            m_halted = 1'b0;
        end else if (r_redir) begin
            m_fifo.delete();
            m_pc     = r_pc & 32'hFFFF_FFFC;
            m_infl   = 1'b0;
            m_halted = 1'b0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (m_infl && !m_halted) begin
                e.w  = mem[m_infl_pc[9:2]];
                e.pc = m_infl_pc;
                m_fifo.push_back(e);
`ifdef FETCH_EBREAK_HALT_EN
                if (e.w == Ebreak) m_halted = 1'b1;
`endif
            end
            m_infl = issue;
            if (issue) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        int          thr;
        logic [31:0] rpc;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            if (v == Ebreak) v = v ^ 32'h1;
            if (i >= 16 && $urandom_range(0, 11) == 0) v = Ebreak;
            mem[i] = v;
        end
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);

        // Reset state.
        run_cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("rst_inst", inst, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);

        // Directed opening: stream, redirect to 0x23, stall, mid-run reset.
        for (int c = 0; c < 24; c++) begin
            run_cycle(c == 18, !(c >= 9 && c <= 13), c == 4, 32'h23);
            if (c == 2) check_eq("first_pc", inst_pc, 32'h0);
            if (c == 3) check_eq("second_pc", inst_pc, 32'h4);
            if (c == 5) check_eq("redir_addr", mem_addr, 32'h20);
            if (c == 5 || c == 6) check_eq("redir_bubble", {31'b0, inst_valid}, 32'h0);
            if (c == 7) check_eq("redir_pc", inst_pc, 32'h20);
            if (c == 11) check_eq("stall_issue", {31'b0, mem_r_enable}, 32'h0);
            if (c == 19) check_eq("post_rst_valid", {31'b0, inst_valid}, 32'h0);
            if (c == 19) check_eq("post_rst_addr", mem_addr, 32'h0);
        end

        // Random traffic with varying decode back-pressure.
        thr = 4;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) thr = $urandom_range(0, 4);
            case ($urandom_range(0, 2))
                0:       rpc = $urandom;
                1:       rpc = $urandom_range(0, 127);
                default: rpc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            endcase
            run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) < thr,
                      $urandom_range(0, 19) == 0, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch initiator for the core's instruction memory. Drives word-aligned read requests into the one-cycle-latency registered read port, captures returned words into a 2-entry output FIFO, and presents them with their PC to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and, optionally, stops fetching after an EBREAK.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits ignored
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- mem_addr  output  32  read address to instruction memory; equals `pc` (combinational)
- mem_r_enable  output  1  read strobe; combinational issue condition
- mem_rdata  input  32  read data, valid the cycle after mem_r_enable=1
- inst  output  32  FIFO head instruction word
- inst_pc  output  32  PC of `inst`
- inst_valid  output  1  FIFO non-empty
- inst_ready  input  1  decode accepts head this cycle
- redirect_valid  input  1  one-cycle redirect request
- redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0
- halted  output  1  fetch stopped on EBREAK

## Operation
- State: pc (32b), pending (1b) + pending_pc, FIFO of 2 entries {word, pc}, count (0..2), halted.
- pop = inst_valid & inst_ready.
- issue = !rst & !redirect_valid & !halted & (count + pending - pop < 2).
- issue: mem_r_enable=1, mem_addr=pc; pc <= pc+4, pending <= 1, pending_pc <= pc. Otherwise pending <= 0.
- pending=1: push {mem_rdata, pending_pc} into FIFO the same cycle (FIFO never overflows given issue rule; simultaneous push+pop allowed).
- redirect_valid (highest priority after rst): FIFO emptied, count <= 0, pending <= 0 (in-flight response dropped), pc <= {redirect_pc[31:2],2'b00}, halted <= 0; no issue, no push, no pop that cycle.
- pc is 32-bit and wraps 0xFFFF_FFFC -> 0; memory only decodes mem_addr[9:2], so 0x400 aliases word 0 — no special handling.
- FIFO entries hold value while not popped; inst/inst_pc stable while inst_valid & !inst_ready.

## Timing
- Reset values: pc=RESET_PC, pending=0, count=0, halted=0, FIFO entries 0 → inst=0, inst_pc=0, inst_valid=0, mem_r_enable=0 while rst=1, mem_addr=RESET_PC.
- First cycle with rst=0 (cycle 0): issue RESET_PC; mem_rdata valid cycle 1; inst_valid=1 cycle 2.
- Issue-to-inst_valid latency: 2 cycles. Steady-state with inst_ready=1: one instruction per cycle, no bubbles.
- inst_ready=0 sustained: at most 2 words buffered; issue stops once count+pending=2; resumes the cycle a pop occurs.
- Redirect at cycle N: mem_r_enable=1 with mem_addr=redirect_pc at N+1; inst_valid for it at N+3. No stale word visible after cycle N.
- rst asserted mid-operation: all state returns to reset values next edge; pending response dropped.

## Configuration
- FETCH_EBREAK_HALT_EN defined: when a pushed word equals 32'h0010_0073, the EBREAK is still pushed and delivered, halted <= 1 same edge; issue blocked from next cycle; a response already pending for PC+4 is dropped (not pushed). halted clears only on redirect or rst.
- Not defined: EBREAK treated as ordinary word; halted tied 0.

## Test plan
- Reset RESET_PC=0, memory words 0..3 distinct, inst_ready=1 -> inst_pc 0,4,8,12 on cycles 2,3,4,5, inst_valid continuous.
- inst_ready=0 for 5 cycles from cycle 2 -> exactly 2 issues then mem_r_enable=0; inst/inst_pc hold 0 stable; on ready=1 stream continues 4,8,... with no gap or duplicate.
- redirect_valid with redirect_pc=0x23 at cycle 4 while pending=1 and count=1 -> inst_valid=0 cycles 5-6, mem_addr=0x20 at cycle 5, inst_pc=0x20 at cycle 7; word for pre-redirect PC never appears.
- FETCH_EBREAK_HALT_EN, program ADD, ADDI, EBREAK at 0x8 -> inst_pc 0,4,8 delivered, halted=1, no word for 0xC delivered, mem_r_enable stays 0; redirect to 0x0 -> halted=0, fetch restarts at 0.
- Same program without macro -> halted=0, fetch continues 0xC, 0x10, ...
- rst=1 for one cycle while count=2 -> next cycle inst_valid=0, mem_addr=RESET_PC, issue resumes following cycle.
